// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: ALU writeback has priority, long-latency
// results queue in a small FIFO, and a busy scoreboard tracks pending writes.
module regfile_write_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_alu_valid,
    input  logic [4:0]  i_alu_addr,
    input  logic [31:0] i_alu_data,
    input  logic        i_ld_valid,
    input  logic [4:0]  i_ld_addr,
    input  logic [31:0] i_ld_data,
    output logic        o_ld_ready,
    input  logic        i_issue_valid,
    input  logic [4:0]  i_issue_addr,
    output logic [4:0]  o_A3,
    output logic [31:0] o_WD3,
    output logic        o_WE3,
    output logic [31:0] o_busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [4:0]       r_fifoAddr  [DEPTH];
    logic [31:0]      r_fifoData  [DEPTH];
    logic [DEPTH-1:0] r_fifoValid;
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_busy;
    logic [4:0]       r_A3;
    logic [31:0]      r_WD3;
    logic             r_WE3;

    logic             w_aluUse;
    logic             w_enq;
    logic             w_deq;
    logic             w_headValid;
    logic [DEPTH-1:0] w_killMask;
    logic             w_anyKill;
    logic [31:0]      w_set;
    logic [31:0]      w_clr;
    logic [31:0]      w_busyNext;

    assign o_ld_ready  = (r_count != CNT_W'(DEPTH));
    assign w_aluUse    = i_alu_valid && (i_alu_addr != 5'd0);
    assign w_enq       = i_ld_valid && o_ld_ready && (i_ld_addr != 5'd0);
    assign w_deq       = !w_aluUse && (r_count != '0);
    assign w_headValid = r_fifoValid[r_rdPtr];

    // A younger ALU write to the same register turns queued entries into holes.
    always_comb begin
        w_killMask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_aluUse && r_fifoValid[i] && (r_fifoAddr[i] == i_alu_addr)) begin
                w_killMask[i] = 1'b1;
            end
        end
        w_anyKill = |w_killMask;
    end

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (i_issue_valid && (i_issue_addr != 5'd0)) begin
            w_set[i_issue_addr] = 1'b1;
        end
        if (w_deq && w_headValid) begin
            w_clr[r_fifoAddr[r_rdPtr]] = 1'b1;
        end
        if (w_anyKill) begin
            w_clr[i_alu_addr] = 1'b1;
        end
        w_busyNext    = (r_busy & ~w_clr) | w_set;
        w_busyNext[0] = 1'b0;
    end

    // Later assignments win: a fresh enqueue is never killed in its arrival cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fifoValid <= '0;
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_count     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fifoAddr[i] <= '0;
                r_fifoData[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_killMask[i]) begin
                    r_fifoValid[i] <= 1'b0;
                end
            end
            if (w_deq) begin
                r_fifoValid[r_rdPtr] <= 1'b0;
                r_rdPtr              <= r_rdPtr + 1'b1;
            end
            if (w_enq) begin
                r_fifoValid[r_wrPtr] <= 1'b1;
                r_fifoAddr[r_wrPtr]  <= i_ld_addr;
                r_fifoData[r_wrPtr]  <= i_ld_data;
                r_wrPtr              <= r_wrPtr + 1'b1;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Address/data hold their last written values whenever no write is issued.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_A3   <= '0;
            r_WD3  <= '0;
            r_WE3  <= 1'b0;
            r_busy <= '0;
        end else begin
            r_busy <= w_busyNext;
            r_WE3  <= 1'b0;
            if (w_aluUse) begin
                r_WE3 <= 1'b1;
                r_A3  <= i_alu_addr;
                r_WD3 <= i_alu_data;
            end else if (w_deq && w_headValid) begin
                r_WE3 <= 1'b1;
                r_A3  <= r_fifoAddr[r_rdPtr];
                r_WD3 <= r_fifoData[r_rdPtr];
            end
        end
    end

    assign o_A3   = r_A3;
    assign o_WD3  = r_WD3;
    assign o_WE3  = r_WE3;
    assign o_busy = r_busy;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter (DEPTH=2).
module tb_regfile_write_arbiter;

    logic        i_clk;
    logic        i_rst;
    logic        i_alu_valid;
    logic [4:0]  i_alu_addr;
    logic [31:0] i_alu_data;
    logic        i_ld_valid;
    logic [4:0]  i_ld_addr;
    logic [31:0] i_ld_data;
    logic        o_ld_ready;
    logic        i_issue_valid;
    logic [4:0]  i_issue_addr;
    logic [4:0]  o_A3;
    logic [31:0] o_WD3;
    logic        o_WE3;
    logic [31:0] o_busy;

    int checks;
    int passed;

    regfile_write_arbiter #(.DEPTH(2)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_alu_valid   (i_alu_valid),
        .i_alu_addr    (i_alu_addr),
        .i_alu_data    (i_alu_data),
        .i_ld_valid    (i_ld_valid),
        .i_ld_addr     (i_ld_addr),
        .i_ld_data     (i_ld_data),
        .o_ld_ready    (o_ld_ready),
        .i_issue_valid (i_issue_valid),
        .i_issue_addr  (i_issue_addr),
        .o_A3          (o_A3),
        .o_WD3         (o_WD3),
        .o_WE3         (o_WE3),
        .o_busy        (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_alu_valid   = 1'b0;
        i_alu_addr    = '0;
        i_alu_data    = '0;
        i_ld_valid    = 1'b0;
        i_ld_addr     = '0;
        i_ld_data     = '0;
        i_issue_valid = 1'b0;
        i_issue_addr  = '0;
    endtask

    task automatic test_reset();
        i_rst         = 1'b1;
        i_alu_valid   = 1'b1; i_alu_addr = 5'd5;  i_alu_data = 32'hFFFF_0000;
        i_ld_valid    = 1'b1; i_ld_addr  = 5'd6;  i_ld_data  = 32'h0000_FFFF;
        i_issue_valid = 1'b1; i_issue_addr = 5'd7;
        step();
        step();
        checks++; if (o_WE3 !== 1'b0) $display("[TB] FAIL reset_we3: got %b expected 0", o_WE3); else passed++;
        checks++; if (o_A3 !== 5'd0) $display("[TB] FAIL reset_a3: got %0d expected 0", o_A3); else passed++;
        checks++; if (o_WD3 !== 32'd0) $display("[TB] FAIL reset_wd3: got %h expected 0", o_WD3); else passed++;
        checks++; if (o_busy !== 32'd0) $display("[TB] FAIL reset_busy: got %h expected 0", o_busy); else passed++;
        i_rst = 1'b0;
        idle();
        checks++; if (o_ld_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", o_ld_ready); else passed++;
        step();
        checks++; if (o_WE3 !== 1'b0) $display("[TB] FAIL post_reset_we3: got %b expected 0", o_WE3); else passed++;
    endtask

    task automatic test_alu();
        i_alu_valid = 1'b1; i_alu_addr = 5'd5; i_alu_data = 32'hDEAD_BEEF;
        step();
        checks++; if (o_WE3 !== 1'b1) $display("[TB] FAIL alu_we3: got %b expected 1", o_WE3); else passed++;
        checks++; if (o_A3 !== 5'd5) $display("[TB] FAIL alu_a3: got %0d expected 5", o_A3); else passed++;
        checks++; if (o_WD3 !== 32'hDEAD_BEEF) $display("[TB] FAIL alu_wd3: got %h expected deadbeef", o_WD3); else passed++;
        i_alu_addr = 5'd0; i_alu_data = 32'h1111_1111;
        step();
        checks++; if (o_WE3 !== 1'b0) $display("[TB] FAIL alu_r0_we3: got %b expected 0", o_WE3); else passed++;
        checks++; if (o_WD3 !== 32'hDEAD_BEEF) $display("[TB] FAIL alu_hold_wd3: got %h expected deadbeef", o_WD3); else passed++;
        idle();
        step();
    endtask

    task automatic test_collision();
        i_alu_valid = 1'b1; i_alu_addr = 5'd3; i_alu_data = 32'hA0;
        i_ld_valid  = 1'b1; i_ld_addr  = 5'd7; i_ld_data  = 32'h1234;
        step();
        checks++; if (o_WE3 !== 1'b1 || o_A3 !== 5'd3 || o_WD3 !== 32'hA0) $display("[TB] FAIL coll_alu0: got we=%b a=%0d d=%h expected 1/3/a0", o_WE3, o_A3, o_WD3); else passed++;
        i_ld_valid = 1'b0; i_alu_data = 32'hA1;
        step();
        checks++; if (o_WE3 !== 1'b1 || o_A3 !== 5'd3 || o_WD3 !== 32'hA1) $display("[TB] FAIL coll_alu1: got we=%b a=%0d d=%h expected 1/3/a1", o_WE3, o_A3, o_WD3); else passed++;
        i_alu_data = 32'hA2;
        step();
        checks++; if (o_WE3 !== 1'b1 || o_A3 !== 5'd3 || o_WD3 !== 32'hA2) $display("[TB] FAIL coll_alu2: got we=%b a=%0d d=%h expected 1/3/a2", o_WE3, o_A3, o_WD3); else passed++;
        idle();
        step();
        checks++; if (o_WE3 !== 1'b1 || o_A3 !== 5'd7 || o_WD3 !== 32'h1234) $display("[TB] FAIL coll_ld: got we=%b a=%0d d=%h expected 1/7/1234", o_WE3, o_A3, o_WD3); else passed++;
        step();
        checks++; if (o_WE3 !== 1'b0) $display("[TB] FAIL coll_empty: got %b expected 0", o_WE3); else passed++;
    endtask

    task automatic test_full();
        i_alu_valid = 1'b1; i_alu_addr = 5'd4; i_alu_data = 32'h44;
        i_ld_valid  = 1'b1; i_ld_addr  = 5'd20; i_ld_data = 32'hAAAA_0001;
        checks++; if (o_ld_ready !== 1'b1) $display("[TB] FAIL full_ready0: got %b expected 1", o_ld_ready); else passed++;
        step();
        i_ld_addr = 5'd21; i_ld_data = 32'hAAAA_0002;
        step();
        checks++; if (o_ld_ready !== 1'b0) $display("[TB] FAIL full_ready_low: got %b expected 0", o_ld_ready); else passed++;
        i_ld_addr = 5'd22; i_ld_data = 32'hAAAA_0003;
        step();
        checks++; if (o_ld_ready !== 1'b0) $display("[TB] FAIL full_held: got %b expected 0", o_ld_ready); else passed++;
        i_alu_valid = 1'b0;
        step();
        checks++; if (o_WE3 !== 1'b1 || o_A3 !== 5'd20 || o_WD3 !== 32'hAAAA_0001) $display("[TB] FAIL full_drain0: got we=%b a=%0d d=%h expected 1/20/aaaa0001", o_WE3, o_A3, o_WD3); else passed++;
        checks++; if (o_ld_ready !== 1'b1) $display("[TB] FAIL full_ready_rise: got %b expected 1", o_ld_ready); else passed++;
        step();
        i_ld_valid = 1'b0;
        checks++; if (o_WE3 !== 1'b1 || o_A3 !== 5'd21 || o_WD3 !== 32'hAAAA_0002) $display("[TB] FAIL full_drain1: got we=%b a=%0d d=%h expected 1/21/aaaa0002", o_WE3, o_A3, o_WD3); else passed++;
        step();
        checks++; if (o_WE3 !== 1'b1 || o_A3 !== 5'd22 || o_WD3 !== 32'hAAAA_0003) $display("[TB] FAIL full_drain2: got we=%b a=%0d d=%h expected 1/22/aaaa0003", o_WE3, o_A3, o_WD3); else passed++;
        idle();
        step();
        checks++; if (o_WE3 !== 1'b0) $display("[TB] FAIL full_empty: got %b expected 0", o_WE3); else passed++;
    endtask

    task automatic test_waw_kill();
        i_issue_valid = 1'b1; i_issue_addr = 5'd9;
        i_alu_valid   = 1'b1; i_alu_addr   = 5'd4; i_alu_data = 32'h55;
        i_ld_valid    = 1'b1; i_ld_addr    = 5'd9; i_ld_data  = 32'hBAD0_BAD0;
        step();
        checks++; if (o_busy !== 32'h0000_0200) $display("[TB] FAIL waw_busy_set: got %h expected 00000200", o_busy); else passed++;
        i_issue_valid = 1'b0; i_ld_valid = 1'b0;
        i_alu_addr = 5'd9; i_alu_data = 32'h0000_600D;
        step();
        checks++; if (o_WE3 !== 1'b1 || o_A3 !== 5'd9 || o_WD3 !== 32'h0000_600D) $display("[TB] FAIL waw_alu: got we=%b a=%0d d=%h expected 1/9/600d", o_WE3, o_A3, o_WD3); else passed++;
        checks++; if (o_busy !== 32'd0) $display("[TB] FAIL waw_busy_clr: got %h expected 0", o_busy); else passed++;
        idle();
        step();
        checks++; if (o_WE3 !== 1'b0 || o_WD3 !== 32'h0000_600D) $display("[TB] FAIL waw_hole: got we=%b d=%h expected 0/600d", o_WE3, o_WD3); else passed++;
        step();
        checks++; if (o_ld_ready !== 1'b1 || o_WE3 !== 1'b0) $display("[TB] FAIL waw_empty: got rdy=%b we=%b expected 1/0", o_ld_ready, o_WE3); else passed++;
    endtask

    task automatic test_scoreboard();
        i_issue_valid = 1'b1; i_issue_addr = 5'd12;
        step();
        checks++; if (o_busy !== 32'h0000_1000) $display("[TB] FAIL sb_set: got %h expected 00001000", o_busy); else passed++;
        i_issue_valid = 1'b0;
        i_ld_valid = 1'b1; i_ld_addr = 5'd12; i_ld_data = 32'hC0C0;
        step();
        i_ld_valid = 1'b0;
        checks++; if (o_busy !== 32'h0000_1000) $display("[TB] FAIL sb_pending: got %h expected 00001000", o_busy); else passed++;
        step();
        checks++; if (o_WE3 !== 1'b1 || o_A3 !== 5'd12 || o_WD3 !== 32'hC0C0) $display("[TB] FAIL sb_drain: got we=%b a=%0d d=%h expected 1/12/c0c0", o_WE3, o_A3, o_WD3); else passed++;
        checks++; if (o_busy !== 32'd0) $display("[TB] FAIL sb_clear: got %h expected 0", o_busy); else passed++;
        i_issue_valid = 1'b1; i_issue_addr = 5'd12;
        step();
        i_issue_valid = 1'b0;
        i_ld_valid = 1'b1; i_ld_addr = 5'd12; i_ld_data = 32'hC0C1;
        step();
        i_ld_valid = 1'b0;
        i_issue_valid = 1'b1; i_issue_addr = 5'd12;
        step();
        checks++; if (o_WE3 !== 1'b1 || o_WD3 !== 32'hC0C1) $display("[TB] FAIL sb_drain2: got we=%b d=%h expected 1/c0c1", o_WE3, o_WD3); else passed++;
        checks++; if (o_busy !== 32'h0000_1000) $display("[TB] FAIL sb_set_wins: got %h expected 00001000", o_busy); else passed++;
        i_issue_addr = 5'd0;
        step();
        checks++; if (o_busy !== 32'h0000_1000) $display("[TB] FAIL sb_issue_r0: got %h expected 00001000", o_busy); else passed++;
        idle();
        i_ld_valid = 1'b1; i_ld_addr = 5'd0; i_ld_data = 32'hEEEE;
        step();
        i_ld_valid = 1'b0;
        step();
        checks++; if (o_WE3 !== 1'b0 || o_ld_ready !== 1'b1) $display("[TB] FAIL ld_r0_discard: got we=%b rdy=%b expected 0/1", o_WE3, o_ld_ready); else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        i_rst  = 1'b1;
        idle();
        test_reset();
        test_alu();
        test_collision();
        test_full();
        test_waw_kill();
        test_scoreboard();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Single-write-port arbiter in front of the 32x32 register file. It merges the ALU writeback stream and the long-latency (load / multi-cycle) return stream onto the file's write port (address, data, write enable). It buffers deferred long-latency results in a small FIFO and keeps a per-register busy scoreboard that decode uses for hazard stalls.

## Interface
Parameters:
- DEPTH, 2: long-latency FIFO entries. Must be a power of two, ≥2.

Ports:
- i_clk  in  1  clock. All logic is on the rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_alu_valid  in  1  ALU writeback request. Always accepted, no backpressure.
- i_alu_addr  in  5  ALU destination register.
- i_alu_data  in  32  ALU result.
- i_ld_valid  in  1  long-latency result valid.
- i_ld_addr  in  5  long-latency destination register.
- i_ld_data  in  32  long-latency result.
- o_ld_ready  out  1  FIFO can accept. Asserted when the FIFO is not full.
- i_issue_valid  in  1  a long-latency op was issued this cycle.
- i_issue_addr  in  5  destination register of the issued op.
- o_A3  out  5  register file write address.
- o_WD3  out  32  register file write data.
- o_WE3  out  1  register file write enable.
- o_busy  out  32  scoreboard; bit r=1 means register r has a pending long-latency write.

## Operation
- The ALU path has absolute priority for the write port.
  - An ALU request with addr≠0 "uses the port" in that cycle.
  - An ALU request with addr=0 is discarded and does not use the port.
- Long-latency handshake:
  - A transfer happens when i_ld_valid && o_ld_ready.
  - o_ld_ready = (count != DEPTH). It depends only on state, never on i_ld_valid.
  - A transfer with i_ld_addr=0 is accepted and discarded. Nothing is enqueued.
- FIFO head drain: the head drains in any cycle where the ALU does not use the port and count>0.
- Enqueue and dequeue in the same cycle are allowed. Count is unchanged.
- Write-after-write kill: if the ALU uses the port with address X, every valid FIFO entry with address X is invalidated in that cycle. The ALU result is treated as younger.
  - Killed entries stay in the FIFO as holes. When a hole reaches the head it drains with o_WE3=0, but it still consumes the drain slot.
  - A transfer arriving in the same cycle as a matching ALU write is enqueued valid. It is not killed.
- Scoreboard:
  - i_issue_valid with addr≠0 sets busy[addr].
  - busy[r] clears when a valid FIFO entry with addr r drains, or when such an entry is killed.
  - If set and clear hit the same register in one cycle, set wins.
  - busy[0] is always 0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.

## Timing
- Reset values: o_A3=0, o_WD3=0, o_WE3=0, o_busy=0, o_ld_ready=1. FIFO is emptied (count=0, pointers=0).
- Reset mid-operation drops all queued entries and busy bits. The cycle after reset release, no write is issued.
- All three write-port outputs are registered.
  - ALU request in cycle N produces o_WE3=1 in cycle N+1.
  - Long-latency transfer in cycle N is enqueued at the N edge. It is eligible to drain in N+1 and appears on the port in N+2 at the earliest.
- Back-to-back ALU traffic starves the FIFO indefinitely. This is by design, and o_ld_ready stays low while the FIFO is full.
- o_busy is registered. It reflects set/clear events from cycle N in cycle N+1.
- When o_WE3=0, o_A3 and o_WD3 hold their previous values.

## Test plan
- Reset: drive i_rst high for 2 cycles with traffic present.
  - Required: all outputs at their reset values.
  - Required: o_ld_ready=1 in the first cycle after release.
- ALU only: alu addr=5, data=0xDEADBEEF in cycle N.
  - Required: o_WE3=1, o_A3=5, o_WD3=0xDEADBEEF in N+1.
  - ALU addr=0 → o_WE3=0.
- Collision: ALU addr=3 in cycles N..N+2 and ld addr=7, data=0x1234 at N.
  - Required: ALU writes at N+1..N+3.
  - Required: ld write (o_A3=7, o_WD3=0x1234) at N+4.
- Full/backpressure (DEPTH=2):
  - With the ALU continuously busy, enqueue 2 entries → o_ld_ready=0.
  - A third i_ld_valid is held off.
  - After the ALU stops, entries drain in order over 2 consecutive cycles. o_ld_ready rises in the cycle after the first drain.
- WAW kill: issue addr=9 (busy[9]=1) and enqueue ld addr=9 while the ALU is busy, then ALU writes addr=9.
  - Required: the ALU value is written.
  - Required: busy[9] clears the next cycle.
  - Required: the hole drains with o_WE3=0, so the stale value is never written.
- Scoreboard: issue addr=12, then ld addr=12 drains → busy[12] clears.
  - Issue addr=12 again in the same cycle as the drain → busy[12] stays 1.
  - Issue addr=0 → busy stays 0.
